wash_phase_timer: RTL
=====================

Name: wash_phase_timer

Overview:
- Plant/sensor emulation stage directly upstream of the washing machine controller. Consumes the controller's actuator outputs and produces its phase-complete status inputs.
- Tracks the wash sequence FILL → DETERGENT → WASH → DRAIN1 → RINSE_FILL → DRAIN2 → SPIN.
- Counts clock cycles while the actuator for the active phase is on, and raises that phase's done flag after a programmed duration.
- Used for closed-loop simulation and as a timer-based substitute for physical sensors.

Parameters:
- CNT_W, 8, width of the phase duration counter.
- FILL_CYCLES, 16, cycles of fill_valve_on before filled.
- DET_CYCLES, 4, cycles of detergent_valve_on before detergent_added.
- WASH_CYCLES, 32, cycles of motor_on before wash_done.
- DRAIN_CYCLES, 12, cycles of drain_valve_on before drained_1 or drained_2.
- RINSE_CYCLES, 16, cycles of fill_valve_on before rinse_filled.
- SPIN_CYCLES, 24, cycles of spin_motor_on before spin_done.
- All durations must lie in 1..2^CNT_W-1 (enforced by an elaboration check).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- door_lock  in  1  from controller; high while a cycle is in progress.
- fill_valve_on  in  1  from controller.
- detergent_valve_on  in  1  from controller.
- motor_on  in  1  from controller.
- drain_valve_on  in  1  from controller.
- spin_motor_on  in  1  from controller.
- filled  out  1  to controller.
- detergent_added  out  1  to controller.
- wash_done  out  1  to controller.
- drained_1  out  1  to controller.
- rinse_filled  out  1  to controller.
- drained_2  out  1  to controller.
- spin_done  out  1  to controller.
- phase  out  4  current state encoding: IDLE=0, FILL=1, DETERGENT=2, WASH=3, DRAIN1=4, RINSE_FILL=5, DRAIN2=6, SPIN=7, COMPLETE=8.
- cycle_complete  out  1  high while in COMPLETE.
- abort  out  1  one-cycle pulse when the sequence is aborted.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, counter 0, all seven done flags 0, phase=0, cycle_complete=0, abort=0.
- All outputs are registered, with no combinational input-to-output paths.
- Each non-IDLE, non-COMPLETE state has exactly one qualifying actuator:
  - FILL and RINSE_FILL: fill_valve_on.
  - DETERGENT: detergent_valve_on.
  - WASH: motor_on.
  - DRAIN1 and DRAIN2: drain_valve_on.
  - SPIN: spin_motor_on.
- Non-qualifying actuators are ignored, including when several are high at once.
- IDLE: if door_lock=1 and fill_valve_on=1, go to FILL with counter=1 (that cycle counts). Otherwise stay in IDLE.
- Counting:
  - Each cycle the qualifying actuator is 1 and the flag is 0, the counter increments.
  - When counter==LIMIT-1 and the actuator is 1, the phase flag is set at the next edge. The flag therefore rises on the edge that ends the LIMIT-th active cycle.
  - Actuator at 0 with flag at 0 is a pause: counter holds, state holds.
- Phase handoff:
  - Once set, a flag stays high while the qualifying actuator stays 1; the counter holds.
  - On the first cycle with flag=1 and actuator=0: at the next edge the flag clears, the counter clears to 0, and the state advances to the next phase.
  - SPIN advances to COMPLETE.
  - The new phase begins counting the cycle after entry, never on the handoff cycle.
- The same drain duration is used for DRAIN1 (drives drained_1) and DRAIN2 (drives drained_2). The two flags are never high together.
- COMPLETE: cycle_complete=1. door_lock=0 returns the block to IDLE next edge, with no abort pulse.
- Abort:
  - Applies when door_lock=0 in any state FILL..SPIN.
  - Next edge: state IDLE, counter 0, all flags 0, abort=1 for exactly one cycle.
  - Abort takes priority over flag set and handoff in the same cycle.
- Counter never wraps: saturation is impossible because the flag stops counting at LIMIT.
- Reset asserted mid-phase clears everything immediately. After release the block waits in IDLE for a fresh fill request.

Test Plan:
- Reset and idle: reset=0 then 1, all actuators 0 → all outputs 0 and phase=0 for 20 cycles. fill_valve_on=1 with door_lock=0 stays in IDLE.
- Fill timing: door_lock=1, fill_valve_on=1 held → filled rises exactly 16 edges after fill starts and stays high. Dropping fill_valve_on → filled=0 and phase=2 on the next edge.
- Pause: in WASH, motor_on on 10 cycles, off 5, on 22 → wash_done after the 32nd active cycle (edge 37). Toggle detergent_valve_on during the gap → no effect.
- Full sequence with a closed-loop controller model: each flag rises once in order, with drained_1 before rinse_filled before drained_2. Sequence ends with cycle_complete=1 and phase=8, then phase=0 after door_lock falls.
- Abort: door_lock=0 at count 5 of DRAIN2 → abort=1 for one cycle, then phase=0 and drained_2 never asserted. Repeat on the exact cycle the flag would rise → abort wins and the flag stays 0.
- Async reset mid-SPIN, asserted between clock edges → outputs clear without waiting for an edge. With all parameters set to 1, each flag rises on the edge after the first active cycle.

Source files
------------

// File: rtl/wash_phase_timer_if.sv
// Actuator/status bundle between the wash controller and the phase timer.
// The controller side is master; the timer is slave.
interface wash_phase_timer_if;
    logic       door_lock;
    logic       fill_valve_on;
    logic       detergent_valve_on;
    logic       motor_on;
    logic       drain_valve_on;
    logic       spin_motor_on;
    logic       filled;
    logic       detergent_added;
    logic       wash_done;
    logic       drained_1;
    logic       rinse_filled;
    logic       drained_2;
    logic       spin_done;
    logic [3:0] phase;
    logic       cycle_complete;
    logic       abort;

    modport master (
        output door_lock, fill_valve_on, detergent_valve_on,
        output motor_on, drain_valve_on, spin_motor_on,
        input  filled, detergent_added, wash_done, drained_1,
        input  rinse_filled, drained_2, spin_done,
        input  phase, cycle_complete, abort
    );

    modport slave (
        input  door_lock, fill_valve_on, detergent_valve_on,
        input  motor_on, drain_valve_on, spin_motor_on,
        output filled, detergent_added, wash_done, drained_1,
        output rinse_filled, drained_2, spin_done,
        output phase, cycle_complete, abort
    );
endinterface

// File: rtl/wash_phase_timer.sv
// Timer-based plant model for the wash controller: counts active actuator
// cycles per phase and raises that phase's done flag after its duration.
module wash_phase_timer #(
    parameter int CNT_W        = 8,
    parameter int FILL_CYCLES  = 16,
    parameter int DET_CYCLES   = 4,
    parameter int WASH_CYCLES  = 32,
    parameter int DRAIN_CYCLES = 12,
    parameter int RINSE_CYCLES = 16,
    parameter int SPIN_CYCLES  = 24
) (
    input logic                clk,
    input logic                reset,
    wash_phase_timer_if.slave  bus
);
    localparam int MAX_LIM = (1 << CNT_W) - 1;

    generate
        if (FILL_CYCLES < 1 || FILL_CYCLES > MAX_LIM ||
            DET_CYCLES < 1 || DET_CYCLES > MAX_LIM ||
            WASH_CYCLES < 1 || WASH_CYCLES > MAX_LIM ||
            DRAIN_CYCLES < 1 || DRAIN_CYCLES > MAX_LIM ||
            RINSE_CYCLES < 1 || RINSE_CYCLES > MAX_LIM ||
            SPIN_CYCLES < 1 || SPIN_CYCLES > MAX_LIM) begin : g_bad_cfg
            $error("wash_phase_timer: duration outside 1..2^CNT_W-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DET_LAST   = CNT_W'(DET_CYCLES - 1);
    localparam logic [CNT_W-1:0] WASH_LAST  = CNT_W'(WASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] RINSE_LAST = CNT_W'(RINSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SPIN_LAST  = CNT_W'(SPIN_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FILL   = 4'd1,
        S_DET    = 4'd2,
        S_WASH   = 4'd3,
        S_DRAIN1 = 4'd4,
        S_RINSE  = 4'd5,
        S_DRAIN2 = 4'd6,
        S_SPIN   = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flag_q, flag_d;
    logic             abort_q, abort_d;
    logic             act;
    logic [CNT_W-1:0] last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        act  = 1'b0;
        last = '0;
        unique case (state_q)
            S_FILL: begin
                act  = bus.fill_valve_on;
                last = FILL_LAST;
            end
            S_DET: begin
                act  = bus.detergent_valve_on;
                last = DET_LAST;
            end
            S_WASH: begin
                act  = bus.motor_on;
                last = WASH_LAST;
            end
            S_DRAIN1, S_DRAIN2: begin
                act  = bus.drain_valve_on;
                last = DRAIN_LAST;
            end
            S_RINSE: begin
                act  = bus.fill_valve_on;
                last = RINSE_LAST;
            end
            S_SPIN: begin
                act  = bus.spin_motor_on;
                last = SPIN_LAST;
            end
            default: begin
                act  = 1'b0;
                last = '0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        abort_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // The request cycle itself is the first active fill cycle.
                if (bus.door_lock && bus.fill_valve_on) begin
                    state_d = S_FILL;
                    cnt_d   = CNT_W'(1);
                    flag_d  = (FILL_LAST == '0);
                end
            end
            S_DONE: begin
                if (!bus.door_lock)
                    state_d = S_IDLE;
            end
            default: begin
                if (!bus.door_lock) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    flag_d  = 1'b0;
                    abort_d = 1'b1;
                end else if (flag_q) begin
                    if (!act) begin
                        state_d = state_t'(state_q + 4'd1);
                        cnt_d   = '0;
                        flag_d  = 1'b0;
                    end
                end else if (act) begin
                    cnt_d  = cnt_q + 1'b1;
                    flag_d = (cnt_q == last);
                end
            end
        endcase
    end

    always_comb begin
        bus.phase           = state_q;
        bus.cycle_complete  = (state_q == S_DONE);
        bus.abort           = abort_q;
        bus.filled          = flag_q && (state_q == S_FILL);
        bus.detergent_added = flag_q && (state_q == S_DET);
        bus.wash_done       = flag_q && (state_q == S_WASH);
        bus.drained_1       = flag_q && (state_q == S_DRAIN1);
        bus.rinse_filled    = flag_q && (state_q == S_RINSE);
        bus.drained_2       = flag_q && (state_q == S_DRAIN2);
        bus.spin_done       = flag_q && (state_q == S_SPIN);
    end
endmodule
